prm_edge_mask_engine: RTL and testbench
=======================================

// Module: prm_edge_mask_engine
// PURPOSE
//   Programmable, sequential successor to the fixed per-edge obstacle truth-table checkers.
//   One sum-of-products table per PRM edge is held in on-chip storage and loaded at runtime.
//   On start, an occupancy vector is evaluated against every edge in turn.
//   Output is one blocked/clear result per edge on a valid/ready stream, plus a blocked-edge count.
//   Sits between the occupancy voxeliser and the roadmap graph-search pruning stage.
// PARAMETERS
//   N_IN    15  occupancy bits per query (the inputs A..O of the fixed checkers; bit0=A)
//   N_EDGE  64  number of edges in the table; power of 2, >=2
//   N_TERM  8   product terms per edge; power of 2, >=1
//   Derived: EW=clog2(N_EDGE), TW=clog2(N_TERM), CW=clog2(N_EDGE+1)
// PORTS
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous, active-low reset
//   cfg_we       in   1       term write strobe
//   cfg_edge     in   EW      edge index of written term
//   cfg_term     in   TW      term slot within edge
//   cfg_care     in   N_IN    1 = literal present in term
//   cfg_val      in   N_IN    required value of present literals (1 = X, 0 = !X)
//   cfg_en       in   1       term enable (0 deletes the term)
//   cfg_err      out  1       1-cycle pulse: write rejected because busy
//   start        in   1       begin scan; occ sampled on same edge
//   occ          in   N_IN    occupancy vector
//   busy         out  1       scan in progress
//   out_valid    out  1       result stream valid
//   out_ready    in   1       result stream ready
//   out_edge     out  EW      edge index of result
//   out_blocked  out  1       1 = edge collides (matches any enabled term)
//   done         out  1       1-cycle pulse after last result accepted
//   blocked_cnt  out  CW      blocked edges in last completed scan
// BEHAVIOUR
//   Reset values:
//     - Outputs busy, out_valid, out_edge, out_blocked, done and cfg_err are 0.
//     - blocked_cnt is 0 and all term enables are cleared, so every edge reads clear.
//     - care/val storage is not reset.
//   Term match: en & (((occ ^ val) & care) == 0).
//     - care == 0 with en=1 is a tautology: the edge is always blocked.
//   Edge result: OR of its N_TERM term matches, evaluated in parallel.
//   FSM IDLE -> SCAN -> DONE -> IDLE:
//     - IDLE: start=1 latches occ, sets rd_idx=0 and busy=1, then goes to SCAN.
//       start while busy or in DONE is ignored.
//     - SCAN, read stage: table row rd_idx is registered in cycle t.
//       Result is registered into out_* in cycle t+1.
//       First out_valid rises 2 cycles after the start edge.
//     - SCAN, stall: when out_valid=1 and out_ready=0, out_* hold stable and the read stage freezes.
//       No result is dropped or duplicated.
//       With out_ready held high, one result is produced per cycle, in order 0..N_EDGE-1.
//     - SCAN, count: a running count increments on each accepted blocked result.
//       When edge N_EDGE-1 is accepted, go to DONE.
//     - DONE: 1 cycle. done=1, blocked_cnt <= running count, busy=0 next cycle, then IDLE.
//       blocked_cnt holds until the next DONE.
//   Config path:
//     - cfg_we in IDLE writes the term in 1 cycle; a start in the same cycle sees the new term.
//     - cfg_we while busy (SCAN or DONE) is dropped and cfg_err pulses.
//   Reset asserted mid-scan: the scan is aborted, outputs go to reset values and the table enables are cleared.
//   out_edge wraps nowhere: the index is bounded by N_EDGE-1; the scan ends there.
// TESTING
//   Sanity check. Reset, start with occ=0, out_ready=1:
//     - 64 results arrive on consecutive cycles, all out_blocked=0, first out_valid at start+2.
//     - done follows, blocked_cnt=0.
//   Single term. Edge 5, term 0: care=0x0003, val=0x0001 (A & !B).
//     - occ=0x0001 -> only edge 5 blocked, blocked_cnt=1.
//     - occ=0x0003 -> edge 5 clear.
//   Multiple terms. Edge 63, term 7 with care=0 (tautology) and edge 63, term 0 with care=0x4000, val=0x4000.
//     - occ=0 -> edge 63 blocked.
//     - Rewrite term 7 with cfg_en=0, then occ=0x4000 -> still blocked; occ=0 -> clear.
//   Backpressure. Toggle out_ready pseudo-randomly:
//     - out_edge sequence is exactly 0..63 with no gaps or repeats.
//     - out_* are stable while stalled.
//     - Results match a software model.
//   Busy protection:
//     - cfg_we during SCAN -> cfg_err pulses and the table is unchanged on the next scan.
//     - start during SCAN -> ignored, with no restart.
//   Mid-scan reset. Drop rst_n at edge 20:
//     - out_valid and busy go to 0 asynchronously.
//     - After release, a scan with occ=0xFFFF gives blocked_cnt=0 because the enables were cleared.

Source files
------------

// File: rtl/prm_edge_mask_if.sv
// rtl/prm_edge_mask_if.sv - Config, scan control and result stream bundle for the PRM edge mask engine
interface prm_edge_mask_if #(
    parameter int N_IN   = 15,
    parameter int N_EDGE = 64,
    parameter int N_TERM = 8
);
    localparam int EW = $clog2(N_EDGE);
    localparam int TW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int CW = $clog2(N_EDGE + 1);

    // Term table write port
    logic            cfg_we;
    logic [EW-1:0]   cfg_edge;
    logic [TW-1:0]   cfg_term;
    logic [N_IN-1:0] cfg_care;
    logic [N_IN-1:0] cfg_val;
    logic            cfg_en;
    logic            cfg_err;

    // Scan control
    logic            start;
    logic [N_IN-1:0] occ;
    logic            busy;
    logic            done;
    logic [CW-1:0]   blocked_cnt;

    // Per-edge result stream
    logic            out_valid;
    logic            out_ready;
    logic [EW-1:0]   out_edge;
    logic            out_blocked;

    // Host side: loads the table, launches scans, consumes results
    modport master (
        output cfg_we, cfg_edge, cfg_term, cfg_care, cfg_val, cfg_en,
        output start, occ, out_ready,
        input  cfg_err, busy, done, blocked_cnt,
        input  out_valid, out_edge, out_blocked
    );

    // Engine side
    modport slave (
        input  cfg_we, cfg_edge, cfg_term, cfg_care, cfg_val, cfg_en,
        input  start, occ, out_ready,
        output cfg_err, busy, done, blocked_cnt,
        output out_valid, out_edge, out_blocked
    );
endinterface

// File: rtl/prm_edge_mask_engine.sv
// rtl/prm_edge_mask_engine.sv - Programmable per-edge sum-of-products obstacle mask, scanned sequentially
module prm_edge_mask_engine #(
    parameter int N_IN   = 15,
    parameter int N_EDGE = 64,
    parameter int N_TERM = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    prm_edge_mask_if.slave bus
);
    localparam int EW = $clog2(N_EDGE);
    localparam int TW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int CW = $clog2(N_EDGE + 1);

    localparam logic [EW-1:0] LAST_EDGE = EW'(N_EDGE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Term table: care/val are plain storage, enables are cleared by reset so
    // stale care/val contents can never produce a hit after power-up.
    logic [N_IN-1:0]   care_mem [N_EDGE][N_TERM];
    logic [N_IN-1:0]   val_mem  [N_EDGE][N_TERM];
    logic [N_TERM-1:0] en_mem   [N_EDGE];

    // Scan context
    logic [N_IN-1:0] occ_q;
    logic [EW-1:0]   rd_idx;
    logic            rd_more;

    // Read stage: one full table row, registered
    logic              s_valid;
    logic [EW-1:0]     s_idx;
    logic [N_IN-1:0]   s_care [N_TERM];
    logic [N_IN-1:0]   s_val  [N_TERM];
    logic [N_TERM-1:0] s_en;
    logic              s_hit;

    // Output register and counters
    logic          out_valid_q;
    logic [EW-1:0] out_edge_q;
    logic          out_blocked_q;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] blocked_cnt_q;
    logic          cfg_err_q;

    logic cfg_ok;
    logic start_ok;
    logic out_free;
    logic out_acc;
    logic last_acc;
    logic s_load;

    // Writes and starts are only honoured while idle; the output slot frees
    // up whenever it is empty or being accepted this cycle.
    assign cfg_ok   = bus.cfg_we && (state == ST_IDLE);
    assign start_ok = bus.start && (state == ST_IDLE);
    assign out_free = !out_valid_q || bus.out_ready;
    assign out_acc  = out_valid_q && bus.out_ready;
    assign last_acc = out_acc && (out_edge_q == LAST_EDGE);
    assign s_load   = rd_more && (!s_valid || out_free);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DONE lasts exactly one cycle after the last result is taken
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_SCAN;
            ST_SCAN: if (last_acc) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Term care/val storage write
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            care_mem[bus.cfg_edge][bus.cfg_term] <= bus.cfg_care;
            val_mem[bus.cfg_edge][bus.cfg_term]  <= bus.cfg_val;
        end
    end

    // Term enable storage; cleared on reset so every edge reads clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < N_EDGE; e++) begin
                en_mem[e] <= '0;
            end
        end else if (cfg_ok) begin
            en_mem[bus.cfg_edge][bus.cfg_term] <= bus.cfg_en;
        end
    end

    // Read-stage control: walk rd_idx 0..N_EDGE-1, freezing while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= '0;
            rd_idx  <= '0;
            rd_more <= 1'b0;
            s_valid <= 1'b0;
            s_idx   <= '0;
            s_en    <= '0;
        end else if (start_ok) begin
            occ_q   <= bus.occ;
            rd_idx  <= '0;
            rd_more <= 1'b1;
            s_valid <= 1'b0;
        end else if (s_load) begin
            s_valid <= 1'b1;
            s_idx   <= rd_idx;
            s_en    <= en_mem[rd_idx];
            rd_idx  <= rd_idx + EW'(1);
            if (rd_idx == LAST_EDGE) begin
                rd_more <= 1'b0;
            end
        end else if (out_free) begin
            s_valid <= 1'b0;
        end
    end

    // Read-stage row data, loaded alongside s_en
    always_ff @(posedge clk) begin
        if (s_load) begin
            for (int t = 0; t < N_TERM; t++) begin
                s_care[t] <= care_mem[rd_idx][t];
                s_val[t]  <= val_mem[rd_idx][t];
            end
        end
    end

    // Edge hit: OR over all enabled terms whose present literals all agree with occ
    always_comb begin
        s_hit = 1'b0;
        for (int t = 0; t < N_TERM; t++) begin
            if (s_en[t] && (((occ_q ^ s_val[t]) & s_care[t]) == '0)) begin
                s_hit = 1'b1;
            end
        end
    end

    // Output register: holds while stalled, otherwise takes whatever the read stage has
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_edge_q    <= '0;
            out_blocked_q <= 1'b0;
        end else if (out_free) begin
            out_valid_q <= s_valid;
            if (s_valid) begin
                out_edge_q    <= s_idx;
                out_blocked_q <= s_hit;
            end
        end
    end

    // Blocked counting: running count per scan, published once in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt       <= '0;
            blocked_cnt_q <= '0;
        end else begin
            if (start_ok) begin
                run_cnt <= '0;
            end else if (out_acc && out_blocked_q) begin
                run_cnt <= run_cnt + CW'(1);
            end
            if (state == ST_DONE) begin
                blocked_cnt_q <= run_cnt;
            end
        end
    end

    // Rejected-write flag: one cycle per write attempted while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && (state != ST_IDLE);
        end
    end

    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.blocked_cnt = blocked_cnt_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_edge    = out_edge_q;
    assign bus.out_blocked = out_blocked_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb/tb_prm_edge_mask_engine.sv - Scoreboard bench for prm_edge_mask_engine
module tb_prm_edge_mask_engine;
    localparam int N_IN   = 15;
    localparam int N_EDGE = 64;
    localparam int N_TERM = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prm_edge_mask_if #(.N_IN(N_IN), .N_EDGE(N_EDGE), .N_TERM(N_TERM)) bus ();

    prm_edge_mask_engine #(.N_IN(N_IN), .N_EDGE(N_EDGE), .N_TERM(N_TERM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference table
    logic [N_IN-1:0] m_care [N_EDGE][N_TERM];
    logic [N_IN-1:0] m_val  [N_EDGE][N_TERM];
    bit              m_en   [N_EDGE][N_TERM];

    typedef struct {
        int e;
        bit b;
    } res_t;
    res_t exp_q[$];

    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // An edge is blocked if some enabled term has every present literal satisfied
    function automatic bit model_blocked(input int e, input logic [N_IN-1:0] o);
        for (int t = 0; t < N_TERM; t++) begin
            if (m_en[e][t]) begin
                bit ok = 1'b1;
                for (int i = 0; i < N_IN; i++) begin
                    if (m_care[e][t][i] && (o[i] != m_val[e][t][i])) ok = 1'b0;
                end
                if (ok) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int e, input int t, input logic [N_IN-1:0] care,
                             input logic [N_IN-1:0] val, input bit en);
        bus.cfg_we   = 1'b1;
        bus.cfg_edge = 6'(e);
        bus.cfg_term = 3'(t);
        bus.cfg_care = care;
        bus.cfg_val  = val;
        bus.cfg_en   = en;
        tick();
        bus.cfg_we = 1'b0;
        m_care[e][t] = care;
        m_val[e][t]  = val;
        m_en[e][t]   = en;
        chk("cfg_err_idle", 32'(bus.cfg_err), 32'd0);
    endtask

    function automatic int push_expected(input logic [N_IN-1:0] o);
        int cnt = 0;
        for (int e = 0; e < N_EDGE; e++) begin
            res_t r;
            r.e = e;
            r.b = model_blocked(e, o);
            exp_q.push_back(r);
            cnt += int'(r.b);
        end
        return cnt;
    endfunction

    task automatic run_scan(input logic [N_IN-1:0] o, input int directed_cnt,
                            input bit lat_chk, input bit inject);
        int cnt;
        int k;
        cnt = push_expected(o);
        bus.occ   = o;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.occ   = 15'($urandom);
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        if (lat_chk) begin
            chk("valid_start_p1", 32'(bus.out_valid), 32'd0);
            tick();
            chk("valid_start_p1b", 32'(bus.out_valid), 32'd0);
            tick();
            chk("valid_start_p2", 32'(bus.out_valid), 32'd1);
        end
        if (inject) begin
            tick();
            tick();
            bus.cfg_we   = 1'b1;
            bus.cfg_edge = 6'd0;
            bus.cfg_term = 3'd0;
            bus.cfg_care = '0;
            bus.cfg_val  = '0;
            bus.cfg_en   = 1'b1;
            bus.start    = 1'b1;
            bus.occ      = ~o;
            tick();
            bus.cfg_we = 1'b0;
            bus.start  = 1'b0;
            chk("cfg_err_pulse", 32'(bus.cfg_err), 32'd1);
            tick();
            chk("cfg_err_clear", 32'(bus.cfg_err), 32'd0);
        end
        k = 0;
        while (!bus.done && k < 4000) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        if (lat_chk) chk("stream_cycles", 32'(k), 32'd64);
        chk("results_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        chk("done_pulse_end", 32'(bus.done), 32'd0);
        chk("busy_clear", 32'(bus.busy), 32'd0);
        chk("blocked_cnt", 32'(bus.blocked_cnt), 32'(cnt));
        if (directed_cnt >= 0) chk("blocked_cnt_directed", 32'(bus.blocked_cnt), 32'(directed_cnt));
    endtask

    // Output monitor: scoreboard pop on every accepted result, hold check while stalled
    bit            stalled = 1'b0;
    logic [5:0]    h_edge;
    logic          h_blk;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_hold", 32'({bus.out_valid, bus.out_edge, bus.out_blocked}),
                    32'({1'b1, h_edge, h_blk}));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("out_edge", 32'(bus.out_edge), 32'(r.e));
                    chk("out_blocked", 32'(bus.out_blocked), 32'(r.b));
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            h_edge  = bus.out_edge;
            h_blk   = bus.out_blocked;
        end
    end

    // Result-side backpressure
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [N_IN-1:0] o;
        for (int e = 0; e < N_EDGE; e++)
            for (int t = 0; t < N_TERM; t++) m_en[e][t] = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_edge = '0;
        bus.cfg_term = '0;
        bus.cfg_care = '0;
        bus.cfg_val  = '0;
        bus.cfg_en   = 1'b0;
        bus.start    = 1'b0;
        bus.occ      = '0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        chk("rst_blocked_cnt", 32'(bus.blocked_cnt), 32'd0);
        chk("rst_out_edge", 32'(bus.out_edge), 32'd0);
        chk("rst_out_blocked", 32'(bus.out_blocked), 32'd0);
        rst_n = 1'b1;
        tick();

        // Empty table: everything clear, full-rate streaming
        run_scan(15'h0000, 0, 1'b1, 1'b0);

        // Single term A & !B on edge 5
        cfg_write(5, 0, 15'h0003, 15'h0001, 1'b1);
        run_scan(15'h0001, 1, 1'b1, 1'b0);
        run_scan(15'h0003, 0, 1'b0, 1'b0);

        // Tautology plus O-term on edge 63
        cfg_write(63, 7, 15'h0000, 15'h0000, 1'b1);
        cfg_write(63, 0, 15'h4000, 15'h4000, 1'b1);
        run_scan(15'h0000, 1, 1'b0, 1'b0);
        cfg_write(63, 7, 15'h0000, 15'h0000, 1'b0);
        run_scan(15'h4000, 1, 1'b0, 1'b0);
        run_scan(15'h0000, 0, 1'b0, 1'b0);

        // Random tables, random occupancy, random backpressure
        rand_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 30; w++) begin
                cfg_write(int'($urandom_range(0, N_EDGE - 1)), int'($urandom_range(0, N_TERM - 1)),
                          15'($urandom & $urandom & $urandom), 15'($urandom),
                          $urandom_range(0, 3) != 0);
            end
            run_scan(15'($urandom), -1, 1'b0, 1'b0);
        end

        // Busy protection: edge 0 emptied, then a rejected tautology write and start mid-scan
        for (int t = 0; t < N_TERM; t++) cfg_write(0, t, 15'h7FFF, 15'h0000, 1'b0);
        o = 15'($urandom);
        run_scan(o, -1, 1'b0, 1'b1);
        run_scan(o, -1, 1'b0, 1'b0);

        // Mid-scan reset at edge 20
        rand_ready = 1'b0;
        void'(push_expected(15'h7FFF));
        bus.occ   = 15'h7FFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        begin
            int k = 0;
            while (k < 500) begin
                @(negedge clk);
                if (bus.out_valid && bus.out_edge == 6'd20) break;
                k++;
            end
            chk("reached_edge20", 32'(bus.out_edge), 32'd20);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        for (int e = 0; e < N_EDGE; e++)
            for (int t = 0; t < N_TERM; t++) m_en[e][t] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_scan(15'h7FFF, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
